regfile_dump: RTL and testbench

- Debug reader for the CPU register file. It walks the architectural registers through one asynchronous read port and streams each (index, value) pair out on a valid/ready interface, for a UART or testbench logger.
- It sits beside the register file on a dedicated debug read port and does not touch the core's write path.
- It replaces ad-hoc per-register debug taps with a single sequential dump.

---
 rtl/regfile_dump_pkg.sv | 23 ++
 rtl/regfile_dump.sv | 143 ++++++++++++++
 tb/tb_regfile_dump.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_pkg.sv
// Shared definitions for the register-file debug dumper.
//   - state encoding of the dump FSM
//   - register index width and default data width, shared with the
//     register file and the CPU top
//   - helper returning the first register index of a dump
package regfile_dump_pkg;

  localparam int REG_IDX_W    = 5;
  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } dump_state_e;

  // x0 is hardwired zero, so a dump may skip it.
  function automatic logic [REG_IDX_W-1:0] first_idx(input bit skip_x0);
    return skip_x0 ? REG_IDX_W'(1) : REG_IDX_W'(0);
  endfunction

endpackage

// File: rtl/regfile_dump.sv
// Debug reader for the CPU register file.
// Walks the architectural registers through one asynchronous read port and
// streams each (index, value) pair on a valid/ready interface.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   start      one-cycle dump request, honoured only when idle
//   abort      stops a dump in progress (no done pulse)
//   rd_addr    index driven to the register file debug read port
//   rd_data    combinational read data for rd_addr
//   out_valid  stream element valid
//   out_ready  consumer accepts the element
//   out_addr   register index of the current element
//   out_data   register value of the current element
//   out_last   high with the final element of the dump
//   busy       high whenever the FSM is not idle
//   done       one-cycle pulse after the last element is accepted
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NUM_REGS = 32,
  parameter bit SKIP_X0  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  output logic [REG_IDX_W-1:0] rd_addr,
  input  logic [XLEN-1:0]      rd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [REG_IDX_W-1:0] out_addr,
  output logic [XLEN-1:0]      out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  localparam logic [REG_IDX_W-1:0] FIRST_IDX = first_idx(SKIP_X0);
  localparam logic [REG_IDX_W-1:0] LAST_IDX  = REG_IDX_W'(NUM_REGS - 1);

  dump_state_e          state_q, state_d;
  logic [REG_IDX_W-1:0] idx_q, idx_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic [REG_IDX_W-1:0] out_addr_q, out_addr_d;
  logic [XLEN-1:0]      out_data_q, out_data_d;
  logic                 handshake;

  assign handshake = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;

    unique case (state_q)
      ST_IDLE: begin
        // abort has no meaning here and is ignored.
        if (start) begin
          idx_d   = FIRST_IDX;
          state_d = ST_READ;
        end
      end

      ST_READ: begin
        if (abort) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          // Value is whatever the register holds at this edge; a core write
          // landing on the same edge is not visible.
          out_data_d  = rd_data;
          out_addr_d  = idx_q;
          out_last_d  = (idx_q == LAST_IDX);
          out_valid_d = 1'b1;
          state_d     = ST_SEND;
        end
      end

      ST_SEND: begin
        // abort wins over a handshake in the same cycle.
        if (abort) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = ST_IDLE;
        end else if (handshake) begin
          out_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            // Leave idx at LAST so the index never wraps.
            out_last_d = 1'b0;
            state_d    = ST_DONE;
          end else begin
            idx_d   = idx_q + REG_IDX_W'(1);
            state_d = ST_READ;
          end
        end
      end

      ST_DONE: begin
        // start is ignored in this cycle as well.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
    end
  end

  assign rd_addr   = idx_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: a small register-file model feeds the debug read
// port, expected elements are queued when a dump is started and compared as
// the DUT hands them over.
module tb_regfile_dump;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, out_ready;
  logic [4:0]  rd_addr, out_addr;
  logic [31:0] rd_data, out_data;
  logic        out_valid, out_last, busy, done;

  // Second instance dumping from x0.
  logic        start_b, abort_b, out_ready_b;
  logic [4:0]  rd_addr_b, out_addr_b;
  logic [31:0] rd_data_b, out_data_b;
  logic        out_valid_b, out_last_b, busy_b, done_b;

  // Register file model with one write port and two async read ports.
  logic [31:0] regs [32];
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic        l;
  } exp_t;
  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int start_edge = 0;
  int d0;

  always #5 clk = ~clk;

  regfile_dump #(.XLEN(32), .NUM_REGS(32), .SKIP_X0(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  regfile_dump #(.XLEN(32), .NUM_REGS(32), .SKIP_X0(1'b0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_addr(out_addr_b), .out_data(out_data_b), .out_last(out_last_b),
    .busy(busy_b), .done(done_b)
  );

  assign rd_data   = regs[rd_addr];
  assign rd_data_b = regs[rd_addr_b];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_en && wr_addr != 5'd0) begin
      regs[wr_addr] <= wr_data;
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Monitor: count done pulses and score every accepted element.
  always @(negedge clk) begin
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (!rst && out_valid && out_ready && !abort) begin
      if (exp_q.size() == 0) begin
        check("sb_extra_elem", 64'(out_valid), 64'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("elem addr=%0d data=%08h last=%0b", out_addr, out_data, out_last);
        check("elem_addr", 64'(out_addr), 64'(e.a));
        check("elem_data", 64'(out_data), 64'(e.d));
        check("elem_last", 64'(out_last), 64'(e.l));
      end
    end
  end

  task automatic push_range(input int first, input int last);
    exp_t e;
    for (int i = first; i <= last; i++) begin
      e.a = 5'(i);
      e.d = regs[i];
      e.l = (i == 31);
      exp_q.push_back(e);
    end
  endtask

  task automatic start_pulse();
    @(posedge clk); #1;
    start = 1'b1;
    start_edge = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_valid_addr(input logic [4:0] a, input int max, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && out_addr == a) && n < max);
    check(tag, 64'({out_valid, out_addr}), 64'({1'b1, a}));
  endtask

  task automatic wait_done(input int base, input int max, input string tag);
    int n = 0;
    while (done_cnt == base && n < max) begin
      @(posedge clk);
      n++;
    end
    check(tag, 64'(done_cnt - base), 64'(1));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    start_b = 1'b0; abort_b = 1'b0; out_ready_b = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_outs", 64'({out_valid, out_last, busy, done}), 64'(0));
    check("rst_addrs", 64'({rd_addr, out_addr}), 64'(0));
    check("rst_data", 64'(out_data), 64'(0));

    // Full dump with x5=31, x6=6.
    write_reg(5'd5, 32'd31);
    write_reg(5'd6, 32'd6);
    push_range(1, 31);
    d0 = done_cnt;
    start_pulse();
    wait_done(d0, 200, "t1_done");
    check("t1_latency", 64'(done_cyc - start_edge), 64'(62));
    check("t1_sb_empty", 64'(exp_q.size()), 64'(0));

    // Backpressure on addr 3 and start while busy at addr 10.
    push_range(1, 31);
    d0 = done_cnt;
    start_pulse();
    wait_valid_addr(5'd2, 40, "t2_reach2");
    @(posedge clk); #1 out_ready = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_stall_valid", 64'(out_valid), 64'(1));
      check("t2_stall_addr", 64'(out_addr), 64'(3));
      check("t2_stall_data", 64'(out_data), 64'(regs[3]));
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("t2_next_addr", 64'({out_valid, out_addr}), 64'({1'b1, 5'd4}));
    wait_valid_addr(5'd10, 40, "t2_reach10");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(d0, 200, "t2_done");
    repeat (6) @(posedge clk);
    check("t2_one_done", 64'(done_cnt - d0), 64'(1));
    check("t2_sb_empty", 64'(exp_q.size()), 64'(0));

    // Abort in SEND at addr 7, same cycle as a handshake.
    push_range(1, 6);
    d0 = done_cnt;
    start_pulse();
    wait_valid_addr(5'd6, 40, "t3_reach6");
    @(posedge clk); #1 out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t3_send7", 64'({out_valid, out_addr}), 64'({1'b1, 5'd7}));
    @(posedge clk); #1 abort = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("t3_abort_outs", 64'({out_valid, out_last, busy}), 64'(0));
    repeat (4) @(posedge clk);
    check("t3_no_done", 64'(done_cnt - d0), 64'(0));
    check("t3_sb_empty", 64'(exp_q.size()), 64'(0));
    push_range(1, 31);
    d0 = done_cnt;
    start_pulse();
    wait_valid_addr(5'd1, 10, "t3_restart1");
    wait_done(d0, 200, "t3_done");

    // Core write to x12 on the same edge as the READ of x12.
    push_range(1, 31);
    d0 = done_cnt;
    start_pulse();
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(busy && !out_valid && rd_addr == 5'd12) && n < 60);
      check("t4_read12", 64'({busy, out_valid, rd_addr}), 64'({1'b1, 1'b0, 5'd12}));
    end
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'hDEADBEEF;
    @(posedge clk); #1 wr_en = 1'b0;
    wait_done(d0, 200, "t4_done");
    check("t4_regs12", 64'(regs[12]), 64'(32'hDEADBEEF));
    push_range(1, 31);
    d0 = done_cnt;
    start_pulse();
    wait_done(d0, 200, "t4_done2");
    check("t4_sb_empty", 64'(exp_q.size()), 64'(0));

    // Reset in the middle of SEND, then a dump from x0.
    out_ready = 1'b0;
    start_pulse();
    wait_valid_addr(5'd1, 10, "t5_send1");
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t5_rst_outs", 64'({out_valid, out_last, busy, done}), 64'(0));
    check("t5_rst_addrs", 64'({rd_addr, out_addr, out_data}), 64'(0));
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!out_valid_b && n < 10);
      $display("elem_b addr=%0d data=%08h last=%0b", out_addr_b, out_data_b, out_last_b);
      check("t5_b_valid", 64'(out_valid_b), 64'(1));
      check("t5_b_addr0", 64'(out_addr_b), 64'(0));
      check("t5_b_data0", 64'(out_data_b), 64'(0));
      check("t5_b_last", 64'(out_last_b), 64'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
